// File: rtl/rv32i_memory_arbiter_pkg.sv
// Shared types and constants for the RV32I single-port memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, FETCH, DATA)
//   BeAllOnes   : wide all-ones byte-enable mask, sliced to the bus width by users
package rv32i_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

  localparam int unsigned MaxBeW = 64;
  localparam logic [MaxBeW-1:0] BeAllOnes = '1;

endpackage

// File: rtl/rv32i_memory_arbiter_if.sv
// Shared request/acknowledge memory bus.
//   master : arbiter side (drives request, address, write data, byte enables)
//   slave  : memory side (drives one-cycle ack and read data)
interface rv32i_memory_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/rv32i_fetch_line.sv
// One-entry tagged instruction buffer.
//   clk_i, rst_i  : clock, synchronous active-high reset (clears entry)
//   fill_i        : fetch response arriving this cycle
//   fill_addr_i   : address the response belongs to
//   fill_data_i   : fetched word
//   pc_i          : current core fetch address
//   hit_o         : buffer holds the word for pc_i
//   data_o        : buffered word
module rv32i_fetch_line #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0] data_q;

  // A response whose address no longer matches pc is stale and dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_i && (fill_addr_i == pc_i)) begin
      valid_q <= 1'b1;
      tag_q   <= fill_addr_i;
      data_q  <= fill_data_i;
    end
  end

  assign hit_o  = valid_q && (tag_q == pc_i);
  assign data_o = data_q;
endmodule

// File: rtl/rv32i_memory_arbiter.sv
// Merges the core's fetch and data ports onto one request/ack memory bus.
//   clock, reset        : clock, synchronous active-high reset
//   pc / instruction / instruction_ready : fetch port
//   memory_transaction, mem_write, alu_result, data_out, byte_enablers,
//   data_advance / read_data, data_ready : data port
//   bus                 : shared memory bus (master side)
// Data accesses have fixed priority; every access returns through IDLE.
module rv32i_memory_arbiter
  import rv32i_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     pc,
  output logic [DATA_W-1:0]     instruction,
  output logic                  instruction_ready,
  input  logic                  memory_transaction,
  input  logic                  mem_write,
  input  logic [ADDR_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     data_out,
  input  logic [DATA_W/8-1:0]   byte_enablers,
  input  logic                  data_advance,
  output logic [DATA_W-1:0]     read_data,
  output logic                  data_ready,
  rv32i_memory_arbiter_if.master bus
);
  arb_state_t          state_q;
  logic                req_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic                data_done_q;
  logic [DATA_W-1:0]   read_data_q;

  logic data_pending;
  logic fetch_hit;
  logic fetch_fill;

  assign data_pending = memory_transaction && !data_done_q;
  // In FETCH, addr_q is the fetch address.
  assign fetch_fill   = (state_q == FETCH) && bus.mem_ack;

  rv32i_fetch_line #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fetch_line (
    .clk_i       (clock),
    .rst_i       (reset),
    .fill_i      (fetch_fill),
    .fill_addr_i (addr_q),
    .fill_data_i (bus.mem_rdata),
    .pc_i        (pc),
    .hit_o       (fetch_hit),
    .data_o      (instruction)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      data_done_q <= 1'b0;
      read_data_q <= '0;
    end else begin
      if (data_done_q && data_advance) data_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (data_pending) begin
            state_q <= DATA;
            req_q   <= 1'b1;
            we_q    <= mem_write;
            addr_q  <= alu_result;
            wdata_q <= data_out;
            be_q    <= byte_enablers;
          end else if (!fetch_hit) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= pc;
            be_q    <= BeAllOnes[DATA_W/8-1:0];
          end
        end
        FETCH: begin
          if (bus.mem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        DATA: begin
          if (bus.mem_ack) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            data_done_q <= 1'b1;
            if (!we_q) read_data_q <= bus.mem_rdata;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req       = req_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_be        = be_q;
  assign instruction_ready = fetch_hit;
  assign read_data         = read_data_q;
  assign data_ready        = data_done_q;
endmodule

// File: tb/tb_rv32i_memory_arbiter.sv
module tb_rv32i_memory_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        instruction_ready;
  logic        memory_transaction;
  logic        mem_write;
  logic [31:0] alu_result;
  logic [31:0] data_out;
  logic [3:0]  byte_enablers;
  logic        data_advance;
  logic [31:0] read_data;
  logic        data_ready;

  rv32i_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  rv32i_memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock              (clock),
    .reset              (reset),
    .pc                 (pc),
    .instruction        (instruction),
    .instruction_ready  (instruction_ready),
    .memory_transaction (memory_transaction),
    .mem_write          (mem_write),
    .alu_result         (alu_result),
    .data_out           (data_out),
    .byte_enablers      (byte_enablers),
    .data_advance       (data_advance),
    .read_data          (read_data),
    .data_ready         (data_ready),
    .bus                (bus_if)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Transaction-level reference: one optional outstanding access, a one-word
  // tagged buffer, and the data-completion flag with its held load value.
  bit          m_busy, m_is_data, m_we;
  logic [31:0] m_addr, m_wdata, m_resp;
  logic [3:0]  m_be;
  int          m_wait;
  bit          b_valid;
  logic [31:0] b_tag, b_data;
  bit          m_done;
  logic [31:0] m_rdata;

  int          next_wait = 0;
  logic [31:0] load_resp = '0;
  bit          ack_v;

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst_v, input logic [31:0] pc_v, input bit mt_v, input bit we_v,
                      input logic [31:0] a_v, input logic [31:0] d_v, input logic [3:0] be_v,
                      input bit adv_v, input bit force_ack);
    bit exp_ready;
    bit done_n;
    @(posedge clock);
    #1;
    reset = rst_v; pc = pc_v; memory_transaction = mt_v; mem_write = we_v;
    alu_result = a_v; data_out = d_v; byte_enablers = be_v; data_advance = adv_v;
    ack_v = force_ack || (m_busy && m_wait == 0);
    bus_if.mem_ack   = ack_v;
    bus_if.mem_rdata = m_busy ? m_resp : $urandom;
    #1;
    if (chk_en) begin
      exp_ready = b_valid && (b_tag == pc_v);
      chk("mem_req", {31'd0, bus_if.mem_req}, {31'd0, m_busy});
      if (m_busy) begin
        chk("mem_addr", bus_if.mem_addr, m_addr);
        chk("mem_we", {31'd0, bus_if.mem_we}, {31'd0, m_is_data && m_we});
        chk("mem_be", {28'd0, bus_if.mem_be}, {28'd0, m_is_data ? m_be : 4'hF});
        if (m_is_data && m_we) chk("mem_wdata", bus_if.mem_wdata, m_wdata);
      end
      chk("instruction_ready", {31'd0, instruction_ready}, {31'd0, exp_ready});
      chk("instruction", instruction, b_valid ? b_data : 32'd0);
      chk("data_ready", {31'd0, data_ready}, {31'd0, m_done});
      chk("read_data", read_data, m_rdata);
    end
    if (rst_v) begin
      m_busy = 0; b_valid = 0; b_tag = '0; b_data = '0; m_done = 0; m_rdata = '0;
    end else begin
      done_n = m_done && !adv_v;
      if (m_busy) begin
        if (ack_v) begin
          if (!m_is_data) begin
            if (m_addr == pc_v) begin
              b_valid = 1; b_tag = m_addr; b_data = m_resp;
            end
          end else begin
            if (!m_we) m_rdata = m_resp;
            done_n = 1;
          end
          m_busy = 0;
        end else if (m_wait != 0) begin
          m_wait--;
        end
      end else if (mt_v && !m_done) begin
        m_busy = 1; m_is_data = 1; m_we = we_v; m_addr = a_v; m_wdata = d_v; m_be = be_v;
        m_resp = load_resp; m_wait = next_wait;
      end else if (!(b_valid && b_tag == pc_v)) begin
        m_busy = 1; m_is_data = 0; m_we = 0; m_addr = pc_v; m_be = 4'hF;
        m_resp = fetch_word(pc_v); m_wait = next_wait;
      end
      m_done = done_n;
    end
  endtask

  bit          seen_wr;
  int          wr_cnt;
  bit          c_mt, c_we, c_adv, done_before;
  logic [31:0] c_pc, c_addr, c_data;
  logic [3:0]  c_be;

  initial begin
    bus_if.mem_ack = 0; bus_if.mem_rdata = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1;

    // Reset values, then zero-wait fetch of pc=0.
    next_wait = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mem_req", {31'd0, bus_if.mem_req}, 32'd0);
    chk("rst_mem_addr", bus_if.mem_addr, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_iready", {31'd0, instruction_ready}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("c1_mem_req", {31'd0, bus_if.mem_req}, 32'd1);
    chk("c1_mem_addr", bus_if.mem_addr, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("c2_iready", {31'd0, instruction_ready}, 32'd1);
    chk("c2_instr", instruction, 32'h0050_0093);

    // Fetch of 0x04 with 3 wait states; store raised mid-fetch must wait.
    next_wait = 3;
    step(0, 32'h4, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h4, 0, 0, 0, 0, 0, 0, 0);
    next_wait = 1;
    seen_wr = 0; wr_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      step(0, 32'h4, 1, 1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 0, 0);
      if (bus_if.mem_req && bus_if.mem_we && ack_v) wr_cnt++;
      if (bus_if.mem_req && bus_if.mem_we && !seen_wr) begin
        seen_wr = 1;
        chk("store_after_fetch", {31'd0, instruction_ready}, 32'd1);
        chk("store_be", {28'd0, bus_if.mem_be}, 32'h3);
      end
    end
    chk("store_seen", {31'd0, seen_wr}, 32'd1);
    chk("store_once", wr_cnt, 32'd1);
    chk("store_ready_held", {31'd0, data_ready}, 32'd1);
    step(0, 32'h4, 1, 1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 1, 0);
    chk("adv_cycle_ready", {31'd0, data_ready}, 32'd1);
    step(0, 32'h4, 0, 0, 0, 0, 0, 0, 0);
    chk("adv_next_ready", {31'd0, data_ready}, 32'd0);

    // pc redirect 0x40 -> 0x80 while the 0x40 fetch waits.
    next_wait = 3;
    step(0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    next_wait = 0;
    step(0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    chk("stale_iready", {31'd0, instruction_ready}, 32'd0);
    step(0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    chk("refetch_addr", bus_if.mem_addr, 32'h80);
    chk("refetch_req", {31'd0, bus_if.mem_req}, 32'd1);
    step(0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    chk("refetch_hit", {31'd0, instruction_ready}, 32'd1);

    // Load held until advance; a later store leaves read_data alone.
    load_resp = 32'h1234_5678;
    for (int i = 0; i < 6; i++) step(0, 32'h80, 1, 0, 32'h200, 0, 4'hF, 0, 0);
    chk("load_data", read_data, 32'h1234_5678);
    step(0, 32'h80, 1, 0, 32'h200, 0, 4'hF, 1, 0);
    step(0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    load_resp = 32'h0BAD_0BAD;
    for (int i = 0; i < 4; i++) step(0, 32'h80, 1, 1, 32'h204, 32'hCAFE_F00D, 4'hF, 0, 0);
    chk("store_keeps_rdata", read_data, 32'h1234_5678);
    chk("store2_ready", {31'd0, data_ready}, 32'd1);
    step(0, 32'h80, 1, 1, 32'h204, 32'hCAFE_F00D, 4'hF, 1, 0);
    step(0, 32'h80, 0, 0, 0, 0, 0, 0, 0);

    // Reset during the second cycle of a DATA request, late ack after.
    next_wait = 3;
    step(0, 32'h80, 1, 1, 32'h300, 32'h5555_AAAA, 4'hC, 0, 0);
    step(0, 32'h80, 1, 1, 32'h300, 32'h5555_AAAA, 4'hC, 0, 0);
    chk("dreq_before_rst", {31'd0, bus_if.mem_req}, 32'd1);
    step(1, 32'h80, 1, 1, 32'h300, 32'h5555_AAAA, 4'hC, 0, 0);
    next_wait = 0;
    step(0, 32'h80, 0, 0, 0, 0, 0, 0, 1);
    chk("mid_rst_req", {31'd0, bus_if.mem_req}, 32'd0);
    chk("mid_rst_we", {31'd0, bus_if.mem_we}, 32'd0);
    chk("mid_rst_addr", bus_if.mem_addr, 32'd0);
    chk("mid_rst_wdata", bus_if.mem_wdata, 32'd0);
    chk("mid_rst_be", {28'd0, bus_if.mem_be}, 32'd0);
    chk("mid_rst_dready", {31'd0, data_ready}, 32'd0);
    chk("mid_rst_rdata", read_data, 32'd0);
    chk("mid_rst_iready", {31'd0, instruction_ready}, 32'd0);
    step(0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    chk("late_ack_ignored", {31'd0, data_ready}, 32'd0);

    // Randomized traffic.
    c_mt = 0; c_we = 0; c_addr = '0; c_data = '0; c_be = '0; c_pc = 32'h80;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) c_pc = 32'($urandom_range(0, 3)) << 2;
      if (!c_mt && $urandom_range(0, 2) == 0) begin
        c_mt = 1; c_we = 1'($urandom_range(0, 1));
        c_addr = $urandom; c_data = $urandom; c_be = 4'($urandom_range(0, 15));
      end
      c_adv = m_done ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      next_wait = $urandom_range(0, 3);
      load_resp = $urandom;
      done_before = m_done;
      step(($urandom_range(0, 299) == 0), c_pc, c_mt, c_we, c_addr, c_data, c_be, c_adv,
           (!m_busy && $urandom_range(0, 7) == 0));
      if (c_adv && done_before) c_mt = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32i_memory_arbiter.md
# rv32i_memory_arbiter

Single-port memory arbiter for the pipelined RV32I core. It merges the core's instruction-fetch port (`pc` / `instruction` / `instruction_ready`) and data port (`memory_transaction`, `mem_write`, `alu_result`, `data_out`, `byte_enablers` / `read_data` / `data_ready`) onto one shared request/acknowledge memory bus. It holds each completed result until the core consumes it, so core stalls never cause a lost or duplicated access. It sits between `RV32I` and the unified memory.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` bits
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `pc` in ADDR_W: core fetch address
- `instruction` out DATA_W: fetched word; valid while `instruction_ready`
- `instruction_ready` out 1: fetch buffer holds the word for the current `pc`
- `memory_transaction` in 1: core M-stage access pending
- `mem_write` in 1: M-stage access is a store
- `alu_result` in ADDR_W: data address
- `data_out` in DATA_W: store data
- `byte_enablers` in DATA_W/8: store byte lanes
- `data_advance` in 1: core memory-stage register loads this cycle; tied to core `enable_memory`
- `read_data` out DATA_W: load result, held while `data_ready`
- `data_ready` out 1: current M-stage access has completed
- `mem_req` out 1: bus request; held until `mem_ack`
- `mem_we` out 1: bus write
- `mem_addr` out ADDR_W: bus address
- `mem_wdata` out DATA_W: bus write data
- `mem_be` out DATA_W/8: bus byte enables
- `mem_ack` in 1: one-cycle completion pulse; may assert in the first `mem_req` cycle
- `mem_rdata` in DATA_W: read data, valid with `mem_ack`

## Operation
- FSM states: IDLE, FETCH, DATA.
- `data_pending = memory_transaction & ~data_done`.
- `fetch_needed = ~(ivalid & itag == pc)`.
- IDLE transitions:
  - If `data_pending`: go to DATA. Latch `alu_result`, `data_out`, `byte_enablers`, `mem_write`. Data has fixed priority.
  - Else if `fetch_needed`: go to FETCH and latch `fetch_addr <= pc`.
  - Else stay in IDLE.
- `mem_req` = (state != IDLE). All `mem_*` outputs are driven from latched registers, so they are stable for the whole request.
- FETCH drives `mem_we=0`, `mem_be=all ones`, `mem_addr=fetch_addr`.
- FETCH + `mem_ack`:
  - If `fetch_addr == pc` this cycle: `ibuf <= mem_rdata`, `itag <= fetch_addr`, `ivalid <= 1`.
  - Otherwise the response is stale and is discarded.
  - Either way, return to IDLE.
- DATA + `mem_ack`: `read_data <= mem_rdata` (loads only; unchanged on stores), `data_done <= 1`, return to IDLE.
- `data_done` clears on `data_advance`. `data_advance` with `data_done=0` has no effect.
- `instruction_ready = ivalid & (itag == pc)`, combinational on `pc`. When the core moves to a new `pc`, a refetch follows automatically. A redirect back to the buffered address hits with no bus access.
- `instruction = ibuf`.
- `data_ready = data_done`.
- A store is issued exactly once per M-stage occupancy, regardless of fetch stalls.
- `mem_ack` in IDLE is ignored.

## Timing
- Reset values:
  - state=IDLE, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_be=0`
  - `ivalid=0`, `itag=0`, `ibuf=0`, `instruction_ready=0`, `instruction=0`
  - `data_done=0`, `data_ready=0`, `read_data=0`
- Fetch miss latency with zero-wait memory:
  - cycle 0: miss seen in IDLE
  - cycle 1: `mem_req=1`, `mem_ack=1`
  - cycle 2: `instruction_ready=1`
  - Each added wait state adds one cycle.
- Every access returns through IDLE. Back-to-back accesses therefore start 2 cycles apart at minimum.
- A pending data access blocks a fetch only until IDLE; an in-flight fetch is never aborted.
- Worst-case data wait = remaining fetch + 1 + data access.
- `pc` changing during FETCH only affects the tag compare in the `mem_ack` cycle.
- `reset` mid-request: return to IDLE next cycle and drop `mem_req`. The memory must tolerate an abandoned request; a late ack is ignored.

## Structure
- Package `rv32i_mem_arb_pkg`: state enum `arb_state_t` {IDLE, FETCH, DATA} and the byte-enable-all-ones constant.
- Sub-module `rv32i_fetch_line`: one-entry tagged instruction buffer (fill, hit compare, reset clear).
- FSM, data latch and `data_done` live in the top.

## Test plan
- Reset, then `pc=0x00`, zero-wait memory returning `0x00500093` -> `mem_req` high in cycle 1 with `mem_addr=0x00`; `instruction_ready=1`, `instruction=0x00500093` in cycle 2.
- Fetch in flight with `mem_ack` delayed 3 cycles; `memory_transaction=1` store to `0x100`, `data_out=0xDEADBEEF`, be=`4'b0011` raised meanwhile -> fetch completes first; DATA request follows with `mem_we=1`, `mem_be=4'b0011`; `data_ready` rises after the ack.
- Store completes; hold `memory_transaction=1` with `data_advance=0` for 5 cycles -> exactly one write on the bus; `data_ready` stays high; it clears the cycle after `data_advance`.
- `pc` changes `0x40`→`0x80` while FETCH of `0x40` waits -> the ack for `0x40` is discarded; `instruction_ready` stays 0; a new FETCH of `0x80` is issued.
- Load from `0x200` returning `0x12345678` -> `read_data=0x12345678` held until `data_advance`; a subsequent store leaves `read_data` unchanged.
- `reset` asserted in the second cycle of a DATA request -> `mem_req=0` next cycle; a late `mem_ack` is ignored; all outputs at reset values.
